mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 196 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   M-stage data-memory access sequencer for the pipelined MIPS core.
//   Places store data into byte lanes, runs a req/ack handshake with a
//   wait-stated data memory, and extracts/extends load data back to 32 bits.
//   Flags misaligned loads/stores and bus timeouts.
//
// Ports
//   clk, reset_n           clock (rising edge), async active-low reset
//   start                  begin an access (sampled only when idle)
//   we, size, sign         1=store/0=load; 0=word 1=half 2=byte 3=word;
//                          load sign-extension select
//   addr, wdata            byte address, store data
//   busy                   pipeline stall request
//   done                   one-cycle completion pulse
//   rdata                  extended load result, held until next load done
//   adel, ades, berr       one-cycle pulses: misaligned load/store, timeout
//   mem_req/we/be/addr/wdata  memory request bus (held stable while busy)
//   mem_ack, mem_rdata     memory completion and read word
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        adel,
  output logic        ades,
  output logic        berr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int           CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_next;
  logic [CW-1:0] wait_cnt;

  // Attributes of the in-flight load, needed when the read word arrives.
  logic [1:0]  lat_size;
  logic        lat_sign;
  logic [1:0]  lat_off;

  logic        misaligned;
  logic [3:0]  place_be;
  logic [31:0] place_wdata;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext;

  // NOTE: every signal driven here gets a default first so no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    misaligned  = 1'b0;
    place_be    = 4'b1111;
    place_wdata = wdata;
    byte_v      = 8'h00;
    half_v      = 16'h0000;
    load_ext    = mem_rdata;

    case (size)
      2'd1:    misaligned = addr[0];
      2'd2:    misaligned = 1'b0;
      default: misaligned = (addr[1:0] != 2'b00);   // word and reserved
    endcase

    // Lane placement; loads always read the full word.
    if (we) begin
      case (size)
        2'd2: begin
          place_be    = 4'b0001 << addr[1:0];
          place_wdata = {4{wdata[7:0]}};
        end
        2'd1: begin
          place_be    = addr[1] ? 4'b1100 : 4'b0011;
          place_wdata = {2{wdata[15:0]}};
        end
        default: begin
          place_be    = 4'b1111;
          place_wdata = wdata;
        end
      endcase
    end

    case (lat_off)
      2'd0:    byte_v = mem_rdata[7:0];
      2'd1:    byte_v = mem_rdata[15:8];
      2'd2:    byte_v = mem_rdata[23:16];
      default: byte_v = mem_rdata[31:24];
    endcase
    half_v = lat_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    case (lat_size)
      2'd2:    load_ext = {{24{lat_sign & byte_v[7]}}, byte_v};
      2'd1:    load_ext = {{16{lat_sign & half_v[15]}}, half_v};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next-state logic. An ack on the timeout cycle still completes normally.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start && !misaligned) state_next = ACCESS;
      ACCESS:  if (mem_ack || wait_cnt == LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Registered outputs and datapath. Reset clears the request bus so an
  // abandoned access drops mem_req immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      adel      <= 1'b0;
      ades      <= 1'b0;
      berr      <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wait_cnt  <= '0;
      lat_size  <= '0;
      lat_sign  <= 1'b0;
      lat_off   <= '0;
    end else begin
      done <= 1'b0;
      adel <= 1'b0;
      ades <= 1'b0;
      berr <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (misaligned) begin
              adel <= ~we;
              ades <= we;
            end else begin
              mem_req   <= 1'b1;
              busy      <= 1'b1;
              mem_we    <= we;
              mem_be    <= place_be;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= place_wdata;
              lat_size  <= size;
              lat_sign  <= sign;
              lat_off   <= addr[1:0];
              wait_cnt  <= '0;
            end
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            if (!mem_we) rdata <= load_ext;
          end else if (wait_cnt == LAST) begin
            mem_req <= 1'b0;
            busy    <= 1'b0;
            berr    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Scoreboard bench: the driver pushes expected memory requests and
//   expected responses (done/adel/ades/berr plus rdata) into queues; an
//   independent monitor pops and compares whenever the DUT presents them.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start, we, sign;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, adel, ades, berr;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .we        (we),
    .size      (size),
    .sign      (sign),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .rdata     (rdata),
    .adel      (adel),
    .ades      (ades),
    .berr      (berr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // kind encoding: {berr, ades, adel, done}
  typedef struct {
    logic [3:0]  kind;
    logic [31:0] rdata;
  } resp_t;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  resp_t resp_q[$];
  req_t  req_q[$];
  logic [31:0] model_rdata = '0;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load extraction, written as shift/mask arithmetic.
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg,
                                           input logic [31:0] a, input logic [31:0] word);
    logic [31:0] v;
    int unsigned off;
    off = a % 4;
    case (sz)
      2'd2: begin
        v = (word >> (8 * off)) & 32'h0000_00FF;
        if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = (word >> (8 * (off / 2) * 2)) & 32'h0000_FFFF;
        if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = word;
    endcase
    return v;
  endfunction

  // One access: drives start at the current negedge, plays the memory
  // with 'waits' wait states (or never acks), and returns at a negedge.
  task automatic access(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rw, input int waits, input bit noack);
    bit    mis;
    int    n;
    resp_t r;
    req_t  q;
    mis = (sz == 2'd1) ? (a % 2 != 0) : (sz == 2'd2) ? 1'b0 : (a % 4 != 0);
    start = 1'b1; we = w; size = sz; sign = sg; addr = a; wdata = wd;
    if (mis) begin
      r.kind  = w ? 4'b0100 : 4'b0010;
      r.rdata = model_rdata;
      resp_q.push_back(r);
    end else begin
      q.we   = w;
      q.addr = a - (a % 4);
      if (!w || sz == 2'd0 || sz == 2'd3) begin
        q.be = 4'b1111; q.wdata = wd;
      end else if (sz == 2'd2) begin
        q.be = 4'(1 << (a % 4)); q.wdata = 32'(wd[7:0]) * 32'h0101_0101;
      end else begin
        q.be = 4'(3 << (a % 4)); q.wdata = 32'(wd[15:0]) * 32'h0001_0001;
      end
      req_q.push_back(q);
      if (noack) begin
        r.kind = 4'b1000;
      end else begin
        r.kind = 4'b0001;
        if (!w) model_rdata = ref_load(sz, sg, a, rw);
      end
      r.rdata = model_rdata;
      resp_q.push_back(r);
    end
    @(negedge clk);
    start = 1'b0; addr = $urandom; wdata = $urandom; size = 2'($urandom); sign = 1'($urandom);
    if (mis) begin
      check("misaligned_no_req", 32'(mem_req), 32'd0);
      check("misaligned_no_busy", 32'(busy), 32'd0);
      return;
    end
    n = 0;
    if (noack) begin
      while (mem_req && n < 4 * TIMEOUT) begin
        n++;
        @(negedge clk);
      end
      check("timeout_req_cycles", 32'(n), 32'(TIMEOUT));
      check("timeout_berr", 32'(berr), 32'd1);
      check("timeout_no_done", 32'(done), 32'd0);
    end else begin
      for (int j = 0; j <= waits; j++) begin
        if (busy) n++;
        mem_ack   = (j == waits);
        mem_rdata = (j == waits) ? rw : $urandom;
        @(negedge clk);
      end
      mem_ack = 1'b0; mem_rdata = $urandom;
      check("busy_cycles", 32'(n), 32'(waits + 1));
      check("busy_released", 32'(busy), 32'd0);
      check("done_pulse", 32'(done), 32'd1);
    end
  endtask

  // Monitor: request bus and response pulses against the queues.
  req_t cur_req;
  logic prev_req = 1'b0;
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (!prev_req) begin
        if (req_q.size() == 0) begin
          check("unexpected_req", 32'(mem_req), 32'd0);
          cur_req.we = mem_we; cur_req.be = mem_be; cur_req.addr = mem_addr; cur_req.wdata = mem_wdata;
        end else begin
          cur_req = req_q.pop_front();
        end
      end
      check("mem_we", 32'(mem_we), 32'(cur_req.we));
      check("mem_be", 32'(mem_be), 32'(cur_req.be));
      check("mem_addr", mem_addr, cur_req.addr);
      if (cur_req.we) check("mem_wdata", mem_wdata, cur_req.wdata);
    end
    prev_req = mem_req;
    if (done || adel || ades || berr) begin
      if (resp_q.size() == 0) begin
        check("unexpected_resp", {28'd0, berr, ades, adel, done}, 32'd0);
      end else begin
        resp_t e;
        e = resp_q.pop_front();
        check("resp_kind", {28'd0, berr, ades, adel, done}, {28'd0, e.kind});
        check("resp_rdata", rdata, e.rdata);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: got running, want finished");
    $fatal(1, "time limit");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; we = 1'b0; size = 2'd0; sign = 1'b0;
    addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_req", 32'(mem_req), 32'd0);
    check("reset_outs", {26'd0, done, adel, ades, berr, mem_we, 1'b0}, 32'd0);
    check("reset_be", 32'(mem_be), 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_wdata", mem_wdata, 32'd0);
    check("reset_rdata", rdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases.
    access(1'b0, 2'd2, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 0, 1'b0);
    check("lb_signed", rdata, 32'hFFFF_FF80);
    access(1'b0, 2'd1, 1'b0, 32'h0000_1002, 32'h0, 32'h80FF_1234, 1, 1'b0);
    check("lhu", rdata, 32'h0000_80FF);
    access(1'b0, 2'd1, 1'b1, 32'h0000_1002, 32'h0, 32'h80FF_1234, 0, 1'b0);
    check("lh", rdata, 32'hFFFF_80FF);
    access(1'b1, 2'd2, 1'b0, 32'h0000_2001, 32'h1234_56AB, 32'h0, 3, 1'b0);
    check("sb_keeps_rdata", rdata, 32'hFFFF_80FF);
    access(1'b0, 2'd0, 1'b0, 32'h0000_0002, 32'h0, 32'h0, 0, 1'b0);
    check("adel_pulse", 32'(adel), 32'd1);
    access(1'b1, 2'd1, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 0, 1'b0);
    check("ades_pulse", 32'(ades), 32'd1);
    access(1'b0, 2'd0, 1'b0, 32'h0000_3000, 32'h0, 32'h0, 0, 1'b1);
    check("timeout_rdata", rdata, 32'hFFFF_80FF);
    access(1'b0, 2'd0, 1'b0, 32'h0000_3004, 32'h0, 32'hCAFE_F00D, TIMEOUT - 1, 1'b0);
    check("ack_on_timeout_cycle", rdata, 32'hCAFE_F00D);
    access(1'b0, 2'd3, 1'b0, 32'h0000_3008, 32'h0, 32'h1357_9BDF, 0, 1'b0);
    check("reserved_size_word", rdata, 32'h1357_9BDF);

    // Ack while idle must be ignored.
    mem_ack = 1'b1;
    repeat (2) @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack_no_done", 32'(done), 32'd0);

    // Reset in the second access cycle abandons the access.
    begin
      req_t q;
      q.we = 1'b0; q.be = 4'b1111; q.addr = 32'h0000_0100; q.wdata = '0;
      req_q.push_back(q);
      start = 1'b1; we = 1'b0; size = 2'd0; addr = 32'h0000_0100;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("async_reset_req", 32'(mem_req), 32'd0);
      check("async_reset_busy", 32'(busy), 32'd0);
      model_rdata = '0;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      check("abandoned_no_done", 32'(done), 32'd0);
    end

    // Randomized accesses, back to back.
    for (int i = 0; i < 80; i++) begin
      logic [1:0] sz;
      sz = 2'($urandom);
      access(1'($urandom), sz, 1'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 4)), ($urandom_range(0, 15) == 0));
    end

    repeat (3) @(negedge clk);
    check("req_queue_drained", 32'(req_q.size()), 32'd0);
    check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
